// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared arbiter state encoding and width helper
package uart_tx_arbiter_pkg;

    localparam int DWIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } arb_state_t;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: rotating-priority picker, first set request at or after ptr
module uart_tx_arbiter_rr_pick #(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) idx = IW'((int'(ptr) + k) % NREQ);
        any = |req;
        onehot = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with gap and start timeout
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 64,
    localparam int IW = $clog2(NREQ),
    localparam int TW = cnt_width(TIMEOUT + 1),
    localparam int GW = cnt_width(GAP_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    input  logic [NREQ-1:0]        req_par_en,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   tx_busy,
    output logic                   tx_data_valid,
    output logic [DWIDTH-1:0]      tx_p_data,
    output logic                   tx_par_en,
    output logic [IW-1:0]          grant_id,
    output logic                   arb_busy,
    output logic                   err_timeout
);

    arb_state_t      state, nxt;
    logic [IW-1:0]   rr_ptr, pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic            pick_any, accept, timeout_hit;
    logic [TW-1:0]   tmo_cnt;
    logic [GW-1:0]   gap_cnt;

    uart_tx_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign accept      = (state == IDLE) && pick_any && !tx_busy;
    assign req_ready   = accept ? pick_oh : '0;
    assign arb_busy    = (state != IDLE);
    assign timeout_hit = (state == WAIT_BUSY) && !tx_busy && (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:      nxt = accept ? ISSUE : IDLE;
            ISSUE:     nxt = WAIT_BUSY;
            WAIT_BUSY: nxt = tx_busy ? WAIT_DONE : timeout_hit ? ((GAP_CYCLES == 0) ? IDLE : GAP) : WAIT_BUSY;
            WAIT_DONE: nxt = tx_busy ? WAIT_DONE : ((GAP_CYCLES == 0) ? IDLE : GAP);
            GAP:       nxt = (gap_cnt == GW'(1)) ? IDLE : GAP;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            tx_p_data     <= '0;
            tx_par_en     <= 1'b0;
            grant_id      <= '0;
            tx_data_valid <= 1'b0;
            err_timeout   <= 1'b0;
            tmo_cnt       <= '0;
            gap_cnt       <= '0;
        end else begin
            state         <= nxt;
            tx_data_valid <= accept;
            err_timeout   <= timeout_hit;
            if (accept) begin
                tx_p_data <= req_data[int'(pick_idx)*DWIDTH +: DWIDTH];
                tx_par_en <= req_par_en[pick_idx];
                grant_id  <= pick_idx;
                rr_ptr    <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
            end
            if (state == ISSUE)
                tmo_cnt <= '0;
            else if (state == WAIT_BUSY && !tx_busy && !timeout_hit)
                tmo_cnt <= tmo_cnt + TW'(1);
            // both the done path and the timeout path enter GAP with a fresh count
            if (nxt == GAP && state != GAP)
                gap_cnt <= GW'(GAP_CYCLES);
            else if (state == GAP)
                gap_cnt <= gap_cnt - GW'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks on a no-gap and a 3-cycle-gap arbiter sharing stimulus
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = 32'h44A52211;
    logic [3:0]  req_par_en = 4'b0100;
    logic        tx_busy = 1'b0;
    logic [7:0]  bytes [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};

    logic [3:0] rr0, rr1;
    logic       tdv0, tdv1, pe0, pe1, ab0, ab1, err0, err1;
    logic [7:0] pd0, pd1;
    logic [1:0] gid0, gid1;

    int tests = 0;
    int fails = 0;
    int k;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(4), .DWIDTH(8), .GAP_CYCLES(0), .TIMEOUT(8)) d0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_par_en(req_par_en), .req_ready(rr0), .tx_busy(tx_busy),
        .tx_data_valid(tdv0), .tx_p_data(pd0), .tx_par_en(pe0),
        .grant_id(gid0), .arb_busy(ab0), .err_timeout(err0)
    );

    uart_tx_arbiter #(.NREQ(4), .DWIDTH(8), .GAP_CYCLES(3), .TIMEOUT(8)) d1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_par_en(req_par_en), .req_ready(rr1), .tx_busy(tx_busy),
        .tx_data_valid(tdv1), .tx_p_data(pd1), .tx_par_en(pe1),
        .grant_id(gid1), .arb_busy(ab1), .err_timeout(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        tx_busy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // reset state
        @(negedge clk);
        #1;
        chk("rst req_ready", rr0, 0);
        chk("rst tdv", tdv0, 0);
        chk("rst data", pd0, 0);
        chk("rst par", pe0, 0);
        chk("rst gid", gid0, 0);
        chk("rst arb_busy", ab0, 0);
        chk("rst err", err0, 0);
        rst = 1'b1;

        // single request, then gap behaviour on d1 and timeout on d0
        req_valid = 4'b0100;
        #1;
        chk("t1 ready", rr0, 4'b0100);
        chk("t1 idle", ab0, 0);
        @(negedge clk); req_valid = '0; #1;
        chk("t1 tdv", tdv0, 1);
        chk("t1 data", pd0, 8'hA5);
        chk("t1 par", pe0, 1);
        chk("t1 gid", gid0, 2);
        chk("t1 ready off", rr0, 0);
        chk("t1 busy", ab0, 1);
        @(negedge clk); #1;
        chk("t1 tdv pulse", tdv0, 0);
        tx_busy = 1'b1;
        @(negedge clk); #1;
        chk("t1 wait_done", ab0, 1);
        @(negedge clk); req_valid = 4'b0001; #1;
        chk("t5 hold busy", rr0, 0);
        @(negedge clk); tx_busy = 1'b0; #1;
        chk("t1 still wait_done", rr0, 0);
        @(negedge clk); #1;
        chk("t1 d0 regrant", rr0, 4'b0001);
        chk("t3 gap T+1", rr1, 0);
        chk("t3 gap busy", ab1, 1);
        @(negedge clk); #1;
        chk("t3 gap T+2", rr1, 0);
        chk("t4 tdv", tdv0, 1);
        chk("t4 gid", gid0, 0);
        chk("t4 data", pd0, 8'h11);
        chk("t4 par", pe0, 0);
        @(negedge clk); #1;
        chk("t3 gap T+3", rr1, 0);
        @(negedge clk); #1;
        chk("t3 accept T+4", rr1, 4'b0001);
        @(negedge clk); req_valid = '0; #1;
        chk("t3 tdv", tdv1, 1);
        chk("t3 gid", gid1, 0);
        chk("t3 data", pd1, 8'h11);
        repeat (5) @(negedge clk);
        #1;
        chk("t4 err early", err0, 0);
        chk("t4 waiting", ab0, 1);
        @(negedge clk); req_valid = 4'b1111; #1;
        chk("t4 err pulse", err0, 1);
        chk("t4 idle", ab0, 0);
        chk("t4 ptr kept", rr0, 4'b0010);
        @(negedge clk); req_valid = '0; #1;
        chk("t4 err end", err0, 0);
        chk("t4 next tdv", tdv0, 1);
        chk("t4 next gid", gid0, 1);
        chk("t4 next data", pd0, 8'h22);
        @(negedge clk); #1;
        chk("t4 d1 err early", err1, 0);
        @(negedge clk); #1;
        chk("t4 d1 err pulse", err1, 1);
        chk("t4 d1 gap", ab1, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("t4 d1 gap end", ab1, 1);
        @(negedge clk); #1;
        chk("t4 d1 idle", ab1, 0);
        chk("t4 d1 err off", err1, 0);

        // all four requesting, 10-cycle frames
        do_reset();
        req_valid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            k = 0;
            while (tdv0 !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("t2 start seen", 32'(k < 20), 1);
            chk("t2 grant", gid0, f % 4);
            chk("t2 data", pd0, bytes[f % 4]);
            tx_busy = 1'b1;
            repeat (10) begin
                @(negedge clk); #1;
                chk("t2 hold during busy", rr0, 0);
            end
            tx_busy = 1'b0;
        end

        // busy high in IDLE blocks the grant
        do_reset();
        tx_busy = 1'b1;
        req_valid = 4'b0001;
        #1;
        chk("t5 blocked", rr0, 0);
        repeat (4) begin
            @(negedge clk); #1;
            chk("t5 blocked", rr0, 0);
        end
        @(negedge clk); tx_busy = 1'b0; #1;
        chk("t5 accept", rr0, 4'b0001);
        @(negedge clk); req_valid = '0; tx_busy = 1'b1; #1;
        chk("t5 tdv", tdv0, 1);
        chk("t5 gid", gid0, 0);

        // reset in WAIT_DONE
        repeat (2) @(negedge clk);
        #1;
        chk("t6 in frame", ab0, 1);
        rst = 1'b0;
        #1;
        chk("t6 arb_busy", ab0, 0);
        chk("t6 tdv", tdv0, 0);
        chk("t6 data", pd0, 0);
        chk("t6 par", pe0, 0);
        chk("t6 gid", gid0, 0);
        chk("t6 err", err0, 0);
        chk("t6 ready", rr0, 0);
        @(negedge clk); rst = 1'b1; tx_busy = 1'b0; req_valid = 4'b1111; #1;
        chk("t6 ptr reset", rr0, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
